// File: rtl/gth_serializer_pkg.sv
// Shared constants, types and layout helper for the TMDS-to-GT word packing path.
package gth_serializer_pkg;

    // TMDS control-period symbols, indexed by {C1, C0}
    localparam logic [9:0] TMDS_CTRL00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL11 = 10'h2AB;

    typedef logic [15:0] diag_cnt_t;

    // Bit offset of channel c, slot s within a packed GT user-data word
    function automatic int unsigned sym_idx(input int unsigned c, input int unsigned s,
                                            input int unsigned pix_per_word,
                                            input int unsigned sym_w);
        return (c * pix_per_word + s) * sym_w;
    endfunction

endpackage

// File: rtl/tmds_word_packer.sv
// Packs per-pixel TMDS symbols of NUM_CH channels into wide GT words, PIX_PER_WORD
// symbols per channel, with valid/ready on both sides and optional idle fill.
module tmds_word_packer
    import gth_serializer_pkg::*;
#(
    parameter int unsigned      NUM_CH       = 3,
    parameter int unsigned      SYM_W        = 10,
    parameter int unsigned      PIX_PER_WORD = 2,
    parameter bit               FILL_IDLE    = 1'b1,
    parameter logic [SYM_W-1:0] IDLE_SYM     = TMDS_CTRL00,
    localparam int unsigned     SLOT_W       = $clog2(PIX_PER_WORD) + 1,
    localparam int unsigned     WORD_W       = NUM_CH * PIX_PER_WORD * SYM_W
) (
    input  logic                    txoutclk_internal,
    input  logic                    reset,
    input  logic [NUM_CH*SYM_W-1:0] sym_in,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic                    resync,
    output logic [WORD_W-1:0]       word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [SLOT_W-1:0]       slot,
    output diag_cnt_t               starve_cnt,
    output logic                    stall_seen
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;
    diag_cnt_t         starve_q;
    logic              stall_q;
    logic              at_last;
    logic              do_write;
    logic              do_idle;

    // Only a completing write needs the output register free; partial slots keep filling
    always_comb begin
        at_last   = (slot_q == LAST_SLOT);
        sym_ready = !reset && !resync && !(at_last && word_valid_q && !word_ready);
        do_write  = sym_ready && (sym_valid || FILL_IDLE);
        do_idle   = sym_ready && !sym_valid && FILL_IDLE;
    end

    always_comb begin
        slot_d       = slot_q;
        asm_d        = asm_q;
        word_d       = word_q;
        word_valid_d = word_valid_q && !word_ready;
        if (resync) begin
            slot_d = '0;
            asm_d  = '0;
        end else if (do_write) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned s = 0; s < PIX_PER_WORD; s++) begin
                    if (SLOT_W'(s) == slot_q) begin
                        asm_d[sym_idx(c, s, PIX_PER_WORD, SYM_W) +: SYM_W] =
                            sym_valid ? sym_in[c*SYM_W +: SYM_W] : IDLE_SYM;
                    end
                end
            end
            if (at_last) begin
                word_d       = asm_d;
                word_valid_d = 1'b1;
                slot_d       = '0;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge txoutclk_internal) begin
        if (reset) begin
            slot_q       <= '0;
            asm_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            asm_q        <= asm_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            stall_q      <= stall_q | (sym_valid & ~sym_ready);
        end
    end

    always_ff @(posedge txoutclk_internal) begin
        if (reset) begin
            starve_q <= '0;
        end else if (do_idle && (starve_q != 16'hFFFF)) begin
            starve_q <= starve_q + 16'd1;
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign slot       = slot_q;
    assign starve_cnt = starve_q;
    assign stall_seen = stall_q;

endmodule

// File: tb/tb_tmds_word_packer.sv
// Self-checking bench for tmds_word_packer: default, no-fill and wide geometries.
module tb_tmds_word_packer;
    import gth_serializer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance A: defaults (3 ch, 10 bit, 2 slots, idle fill)
    logic        a_reset, a_sym_valid, a_sym_ready, a_resync, a_word_valid, a_word_ready;
    logic [29:0] a_sym_in;
    logic [59:0] a_word_out;
    logic [1:0]  a_slot;
    logic [15:0] a_starve;
    logic        a_stall;

    tmds_word_packer u_a (
        .txoutclk_internal(clk),      .reset(a_reset),
        .sym_in(a_sym_in),            .sym_valid(a_sym_valid),   .sym_ready(a_sym_ready),
        .resync(a_resync),            .word_out(a_word_out),     .word_valid(a_word_valid),
        .word_ready(a_word_ready),    .slot(a_slot),             .starve_cnt(a_starve),
        .stall_seen(a_stall)
    );

    // Instance B: defaults but stall instead of idle fill
    logic        b_reset, b_sym_valid, b_sym_ready, b_resync, b_word_valid, b_word_ready;
    logic [29:0] b_sym_in;
    logic [59:0] b_word_out;
    logic [1:0]  b_slot;
    logic [15:0] b_starve;
    logic        b_stall;

    tmds_word_packer #(.FILL_IDLE(1'b0)) u_b (
        .txoutclk_internal(clk),      .reset(b_reset),
        .sym_in(b_sym_in),            .sym_valid(b_sym_valid),   .sym_ready(b_sym_ready),
        .resync(b_resync),            .word_out(b_word_out),     .word_valid(b_word_valid),
        .word_ready(b_word_ready),    .slot(b_slot),             .starve_cnt(b_starve),
        .stall_seen(b_stall)
    );

    // Instance C: 4 ch, 8 bit, 4 slots
    logic         c_reset, c_sym_valid, c_sym_ready, c_resync, c_word_valid, c_word_ready;
    logic [31:0]  c_sym_in;
    logic [127:0] c_word_out;
    logic [2:0]   c_slot;
    logic [15:0]  c_starve;
    logic         c_stall;

    tmds_word_packer #(.NUM_CH(4), .SYM_W(8), .PIX_PER_WORD(4), .FILL_IDLE(1'b0),
                       .IDLE_SYM(8'h54)) u_c (
        .txoutclk_internal(clk),      .reset(c_reset),
        .sym_in(c_sym_in),            .sym_valid(c_sym_valid),   .sym_ready(c_sym_ready),
        .resync(c_resync),            .word_out(c_word_out),     .word_valid(c_word_valid),
        .word_ready(c_word_ready),    .slot(c_slot),             .starve_cnt(c_starve),
        .stall_seen(c_stall)
    );

    // Reference model for instance A: a queue of accepted pixels and one output word
    logic [29:0] m_part[$];
    logic [59:0] m_word;
    bit          m_valid;
    bit          m_stall;
    int unsigned m_starve;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_part.delete();
        m_word   = '0;
        m_valid  = 1'b0;
        m_stall  = 1'b0;
        m_starve = 0;
    endtask

    // Drives one cycle of A's inputs and advances the model; returns the expected sym_ready
    task automatic drive_a(input bit v, input logic [29:0] d, input bit rdy, input bit rs,
                           output bit exp_rdy);
        logic [29:0] pix;
        bit          loaded;
        a_sym_valid  = v;
        a_sym_in     = d;
        a_word_ready = rdy;
        a_resync     = rs;
        loaded       = 1'b0;
        exp_rdy      = !rs && !((m_part.size() == 1) && m_valid && !rdy);
        if (v && !exp_rdy) m_stall = 1'b1;
        if (rs) begin
            m_part.delete();
        end else if (exp_rdy) begin
            pix = v ? d : {3{TMDS_CTRL00}};
            if (!v && m_starve < 65535) m_starve++;
            m_part.push_back(pix);
            if (m_part.size() == 2) begin
                for (int s = 0; s < 2; s++) begin
                    pix = m_part[s];
                    for (int c = 0; c < 3; c++) m_word[(c*2 + s)*10 +: 10] = pix[c*10 +: 10];
                end
                m_part.delete();
                loaded = 1'b1;
            end
        end
        if (loaded) m_valid = 1'b1;
        else if (rdy) m_valid = 1'b0;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        a_sym_valid = 1'b1; a_sym_in = 30'h1234567; a_word_ready = 1'b0; a_resync = 1'b0;
        tick();
        tick();
        model_reset();
        tests_run++;
        if (a_sym_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sym_ready: got %b expected 0", a_sym_ready);
        end
        tests_run++;
        if (a_word_valid !== 1'b0 || a_word_out !== 60'd0 || a_slot !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b word=%h slot=%0d expected 0/0/0",
                     a_word_valid, a_word_out, a_slot);
        end
        tests_run++;
        if (a_starve !== 16'd0 || a_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_diag: got starve=%0d stall=%b expected 0/0", a_starve, a_stall);
        end
        tests_run++;
        if (c_word_valid !== 1'b0 || c_slot !== 3'd0 || c_word_out !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_wide: got valid=%b slot=%0d expected 0/0", c_word_valid, c_slot);
        end
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    endtask

    task automatic test_basic();
        bit          er;
        logic [59:0] exp_w;
        logic [29:0] d;
        exp_w = {10'h013, 10'h003, 10'h012, 10'h002, 10'h011, 10'h001};
        drive_a(1'b1, {10'h003, 10'h002, 10'h001}, 1'b1, 1'b0, er);
        #1;
        tests_run++;
        if (a_sym_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready: got %b expected 1", a_sym_ready);
        end
        tick();
        tests_run++;
        if (a_slot !== 2'd1 || a_word_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_first: got slot=%0d valid=%b expected 1/0", a_slot, a_word_valid);
        end
        drive_a(1'b1, {10'h013, 10'h012, 10'h011}, 1'b1, 1'b0, er);
        tick();
        tests_run++;
        if (a_word_valid !== 1'b1 || a_word_out !== exp_w || a_slot !== 2'd0) begin
            tests_failed++;
            $display("FAIL basic_word: got valid=%b word=%h slot=%0d expected 1/%h/0",
                     a_word_valid, a_word_out, a_slot, exp_w);
        end
        for (int i = 0; i < 6; i++) begin
            d = 30'($urandom());
            drive_a(1'b1, d, 1'b1, 1'b0, er);
            tick();
            tests_run++;
            if (a_word_valid !== ((i % 2) == 1) ||
                (a_word_valid && a_word_out !== m_word)) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got valid=%b word=%h expected %b/%h",
                         i, a_word_valid, a_word_out, (i % 2) == 1, m_word);
            end
        end
    endtask

    task automatic test_idle();
        bit er;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 30'($urandom()), 1'b1, 1'b0, er);
            tick();
            if (i == 1) begin
                tests_run++;
                if (a_word_valid !== 1'b1 || a_word_out !== {6{10'h354}}) begin
                    tests_failed++;
                    $display("FAIL idle_word: got valid=%b word=%h expected 1/%h",
                             a_word_valid, a_word_out, {6{10'h354}});
                end
            end
        end
        tests_run++;
        if (a_starve !== 16'd3 || a_slot !== 2'd1) begin
            tests_failed++;
            $display("FAIL idle_starve: got starve=%0d slot=%0d expected 3/1", a_starve, a_slot);
        end
    endtask

    task automatic test_backpressure();
        bit          er;
        logic [59:0] w1;
        logic [29:0] x3;
        drive_a(1'b0, '0, 1'b1, 1'b1, er);
        tick();
        tests_run++;
        if (a_slot !== 2'd0) begin
            tests_failed++;
            $display("FAIL bp_resync_slot: got %0d expected 0", a_slot);
        end
        drive_a(1'b1, 30'($urandom()), 1'b1, 1'b0, er);
        tick();
        drive_a(1'b1, 30'($urandom()), 1'b1, 1'b0, er);
        tick();
        w1 = m_word;
        drive_a(1'b1, 30'($urandom()), 1'b0, 1'b0, er);
        tick();
        tests_run++;
        if (a_slot !== 2'd1 || a_word_out !== w1 || a_word_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_partial: got slot=%0d word=%h expected 1/%h", a_slot, a_word_out, w1);
        end
        x3 = 30'($urandom());
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, x3, 1'b0, 1'b0, er);
            #1;
            tests_run++;
            if (a_sym_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_ready[%0d]: got %b expected 0", i, a_sym_ready);
            end
            tick();
            tests_run++;
            if (a_word_out !== w1 || a_word_valid !== 1'b1 || a_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got word=%h valid=%b stall=%b expected %h/1/1",
                         i, a_word_out, a_word_valid, a_stall, w1);
            end
        end
        drive_a(1'b1, x3, 1'b1, 1'b0, er);
        tick();
        tests_run++;
        if (a_word_valid !== 1'b1 || a_word_out !== m_word || a_word_out === w1) begin
            tests_failed++;
            $display("FAIL bp_release: got word=%h valid=%b expected %h/1",
                     a_word_out, a_word_valid, m_word);
        end
    endtask

    task automatic test_resync();
        bit          er;
        logic [29:0] z0, z1;
        logic [59:0] exp_w;
        drive_a(1'b1, 30'($urandom()), 1'b1, 1'b0, er);
        tick();
        drive_a(1'b1, 30'($urandom()), 1'b1, 1'b1, er);
        #1;
        tests_run++;
        if (a_sym_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL resync_ready: got %b expected 0", a_sym_ready);
        end
        tick();
        tests_run++;
        if (a_slot !== 2'd0) begin
            tests_failed++;
            $display("FAIL resync_slot: got %0d expected 0", a_slot);
        end
        z0 = 30'($urandom());
        z1 = 30'($urandom());
        for (int c = 0; c < 3; c++) begin
            exp_w[(c*2)*10 +: 10]     = z0[c*10 +: 10];
            exp_w[(c*2 + 1)*10 +: 10] = z1[c*10 +: 10];
        end
        drive_a(1'b1, z0, 1'b1, 1'b0, er);
        tick();
        drive_a(1'b1, z1, 1'b1, 1'b0, er);
        tick();
        tests_run++;
        if (a_word_valid !== 1'b1 || a_word_out !== exp_w) begin
            tests_failed++;
            $display("FAIL resync_word: got valid=%b word=%h expected 1/%h",
                     a_word_valid, a_word_out, exp_w);
        end
    endtask

    task automatic test_random();
        bit er;
        for (int i = 0; i < 400; i++) begin
            drive_a($urandom_range(0, 9) < 7, 30'($urandom()), $urandom_range(0, 9) < 6,
                    $urandom_range(0, 99) < 3, er);
            #1;
            tests_run++;
            if (a_sym_ready !== er) begin
                tests_failed++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, a_sym_ready, er);
            end
            tick();
            tests_run++;
            if (a_word_valid !== m_valid || (m_valid && a_word_out !== m_word) ||
                a_slot !== 2'(m_part.size()) || a_starve !== 16'(m_starve) ||
                a_stall !== m_stall) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: got v=%b w=%h s=%0d st=%0d sl=%b exp %b/%h/%0d/%0d/%b",
                         i, a_word_valid, a_word_out, a_slot, a_starve, a_stall,
                         m_valid, m_word, m_part.size(), m_starve, m_stall);
            end
        end
    endtask

    task automatic test_no_fill();
        logic [29:0] s0, s1;
        logic [59:0] exp_w;
        s0 = 30'($urandom());
        s1 = 30'($urandom());
        for (int c = 0; c < 3; c++) begin
            exp_w[(c*2)*10 +: 10]     = s0[c*10 +: 10];
            exp_w[(c*2 + 1)*10 +: 10] = s1[c*10 +: 10];
        end
        b_word_ready = 1'b1;
        b_sym_valid  = 1'b1;
        b_sym_in     = s0;
        tick();
        b_sym_valid = 1'b0;
        b_sym_in    = 30'($urandom());
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (b_slot !== 2'd1 || b_word_valid !== 1'b0 || b_starve !== 16'd0) begin
                tests_failed++;
                $display("FAIL nofill_hold[%0d]: got slot=%0d valid=%b starve=%0d expected 1/0/0",
                         i, b_slot, b_word_valid, b_starve);
            end
        end
        b_sym_valid = 1'b1;
        b_sym_in    = s1;
        tick();
        b_sym_valid = 1'b0;
        tests_run++;
        if (b_word_valid !== 1'b1 || b_word_out !== exp_w) begin
            tests_failed++;
            $display("FAIL nofill_word: got valid=%b word=%h expected 1/%h",
                     b_word_valid, b_word_out, exp_w);
        end
    endtask

    task automatic test_wide();
        logic [127:0] exp_w;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) exp_w[(c*4 + s)*8 +: 8] = 8'(4*s + c);
        c_word_ready = 1'b1;
        c_sym_valid  = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) c_sym_in[c*8 +: 8] = 8'(4*p + c);
            tick();
            tests_run++;
            if (c_slot !== 3'((p + 1) % 4)) begin
                tests_failed++;
                $display("FAIL wide_slot[%0d]: got %0d expected %0d", p, c_slot, (p + 1) % 4);
            end
        end
        tests_run++;
        if (c_word_valid !== 1'b1 || c_word_out !== exp_w || c_word_out[31:0] !== 32'h0C080400) begin
            tests_failed++;
            $display("FAIL wide_word: got valid=%b word=%h expected 1/%h",
                     c_word_valid, c_word_out, exp_w);
        end
        c_word_ready = 1'b0;
        for (int p = 4; p < 6; p++) begin
            for (int c = 0; c < 4; c++) c_sym_in[c*8 +: 8] = 8'(4*p + c);
            tick();
        end
        tests_run++;
        if (c_slot !== 3'd2 || c_word_valid !== 1'b1 || c_word_out !== exp_w) begin
            tests_failed++;
            $display("FAIL wide_partial: got slot=%0d valid=%b expected 2/1", c_slot, c_word_valid);
        end
        c_reset = 1'b1;
        tick();
        tests_run++;
        if (c_slot !== 3'd0 || c_word_valid !== 1'b0 || c_word_out !== 128'd0) begin
            tests_failed++;
            $display("FAIL wide_reset: got slot=%0d valid=%b word=%h expected 0/0/0",
                     c_slot, c_word_valid, c_word_out);
        end
        c_reset     = 1'b0;
        c_sym_valid = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_sym_valid = 1'b0; a_sym_in = '0; a_resync = 1'b0; a_word_ready = 1'b0;
        b_reset = 1'b1; b_sym_valid = 1'b0; b_sym_in = '0; b_resync = 1'b0; b_word_ready = 1'b0;
        c_reset = 1'b1; c_sym_valid = 1'b0; c_sym_in = '0; c_resync = 1'b0; c_word_ready = 1'b0;
        test_reset();
        test_basic();
        test_idle();
        test_backpressure();
        test_resync();
        test_random();
        test_no_fill();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
